// File: rtl/tqvp_dlmiles_i2c_pkg.sv
// Shared definitions for the I2C master byte sequencer: PHY command codes,
// TX entry direction encoding and sequencer state encodings.
package tqvp_dlmiles_i2c_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_STOP  = 2'd1,
    CMD_WBIT  = 2'd2,
    CMD_RBIT  = 2'd3
  } phy_cmd_e;

  localparam logic DIR_TXD = 1'b0;
  localparam logic DIR_RXD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_LOAD  = 3'd2,
    ST_BITS  = 3'd3,
    ST_ACK   = 3'd4,
    ST_STOP  = 3'd5
  } seq_state_e;

  localparam logic [2:0] BIT_FIRST = 3'd7;
  localparam logic [2:0] BIT_LAST  = 3'd0;

  // TX entry layout: [8]=direction, [7:0]=write byte or read flags
  function automatic logic entry_is_read(input logic [8:0] entry);
    return entry[8] == DIR_RXD;
  endfunction

endpackage

// File: rtl/tqvp_dlmiles_i2c_seq.sv
// I2C master byte sequencer: turns {dir,data} TX FIFO entries into START/STOP
// and per-bit PHY commands, collects ACKs and pushes read bytes to the RX FIFO.
module tqvp_dlmiles_i2c_seq
  import tqvp_dlmiles_i2c_pkg::*;
#(
  parameter bit NACK_FLUSH = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ctl_enable_i,
  input  logic       stb_restart_i,
  input  logic       stb_stop_i,
  input  logic       stb_clear_i,
  input  logic [8:0] i2c_txd_data_i,
  input  logic       i2c_txd_valid_i,
  output logic       i2c_txd_ready_o,
  output logic [7:0] i2c_rxd_data_o,
  output logic       i2c_rxd_valid_o,
  input  logic       st_rx_full_i,
  output logic [1:0] phy_cmd_o,
  output logic       phy_wbit_o,
  output logic       phy_cmd_valid_o,
  input  logic       phy_cmd_ready_i,
  input  logic       phy_done_i,
  input  logic       phy_rbit_i,
  output logic       tx_flush_o,
  output logic       st_busy_o,
  output logic       st_nack_o
);

  seq_state_e state_r;
  phy_cmd_e   cmd_r;
  logic       wbit_r;
  logic       cmd_valid_r;
  logic       wait_r;
  logic [2:0] bitcnt_r;
  logic [7:0] shift_r;
  logic       dir_r;
  logic       ack_flag_r;
  logic [7:0] rx_data_r;
  logic       restart_pend_r;
  logic       stop_pend_r;
  logic       busy_r;
  logic       nack_r;
  logic       flush_r;

  phy_cmd_e   issue_cmd_s;
  logic       issue_wbit_s;
  logic       pop_s;

  // Command the current state wants to issue to the PHY
  always_comb begin
    issue_cmd_s  = CMD_START;
    issue_wbit_s = 1'b0;
    case (state_r)
      ST_BITS: begin
        if (dir_r == DIR_RXD) begin
          issue_cmd_s = CMD_RBIT;
        end else begin
          issue_cmd_s  = CMD_WBIT;
          issue_wbit_s = shift_r[7];
        end
      end
      ST_ACK: begin
        if (dir_r == DIR_RXD) begin
          issue_cmd_s  = CMD_WBIT;
          issue_wbit_s = ack_flag_r;
        end else begin
          issue_cmd_s = CMD_RBIT;
        end
      end
      ST_STOP: issue_cmd_s = CMD_STOP;
      default: issue_cmd_s = CMD_START;
    endcase
  end

  // Pop decision in LOAD; a read entry waits while the RX FIFO has no room
  always_comb begin
    pop_s = 1'b0;
    if ((state_r == ST_LOAD) && !restart_pend_r && ctl_enable_i && i2c_txd_valid_i &&
        !(entry_is_read(i2c_txd_data_i) && st_rx_full_i)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Sequencer FSM, PHY handshake, shift register and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      cmd_r          <= CMD_START;
      wbit_r         <= 1'b0;
      cmd_valid_r    <= 1'b0;
      wait_r         <= 1'b0;
      bitcnt_r       <= 3'd0;
      shift_r        <= 8'h00;
      dir_r          <= 1'b0;
      ack_flag_r     <= 1'b0;
      rx_data_r      <= 8'h00;
      restart_pend_r <= 1'b0;
      stop_pend_r    <= 1'b0;
      busy_r         <= 1'b0;
      nack_r         <= 1'b0;
      flush_r        <= 1'b0;
    end else begin
      flush_r <= 1'b0;
      if (stb_stop_i) stop_pend_r <= 1'b1;
      if (stb_restart_i && (state_r != ST_IDLE)) restart_pend_r <= 1'b1;
      if (stb_clear_i) nack_r <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (ctl_enable_i && i2c_txd_valid_i) state_r <= ST_START;
        end
        ST_LOAD: begin
          if (restart_pend_r) begin
            restart_pend_r <= 1'b0;
            state_r        <= ST_START;
          end else if (!ctl_enable_i) begin
            state_r <= ST_STOP;
          end else if (pop_s) begin
            dir_r      <= i2c_txd_data_i[8];
            ack_flag_r <= i2c_txd_data_i[0];
            shift_r    <= i2c_txd_data_i[7:0];
            bitcnt_r   <= BIT_FIRST;
            state_r    <= ST_BITS;
          end else if (!i2c_txd_valid_i && stop_pend_r) begin
            state_r <= ST_STOP;
          end
        end
        default: begin
          // One command outstanding: issue, hold until accepted, then await done
          if (wait_r) begin
            if (phy_done_i) begin
              wait_r <= 1'b0;
              case (state_r)
                ST_START: state_r <= ST_LOAD;
                ST_BITS: begin
                  shift_r <= {shift_r[6:0], phy_rbit_i};
                  if (bitcnt_r == BIT_LAST) begin
                    rx_data_r <= {shift_r[6:0], phy_rbit_i};
                    state_r   <= ST_ACK;
                  end else begin
                    bitcnt_r <= bitcnt_r - 3'd1;
                  end
                end
                ST_ACK: begin
                  if ((dir_r == DIR_TXD) && phy_rbit_i) begin
                    nack_r  <= 1'b1;
                    flush_r <= NACK_FLUSH;
                    state_r <= ST_STOP;
                  end else begin
                    state_r <= ST_LOAD;
                  end
                end
                ST_STOP: begin
                  busy_r      <= 1'b0;
                  stop_pend_r <= 1'b0;
                  state_r     <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
              endcase
            end
          end else if (cmd_valid_r) begin
            if (phy_cmd_ready_i) begin
              cmd_valid_r <= 1'b0;
              wait_r      <= 1'b1;
              if (state_r == ST_START) busy_r <= 1'b1;
            end
          end else begin
            cmd_valid_r <= 1'b1;
            cmd_r       <= issue_cmd_s;
            wbit_r      <= issue_wbit_s;
          end
        end
      endcase
    end
  end

  assign phy_cmd_o       = cmd_r;
  assign phy_wbit_o      = wbit_r;
  assign phy_cmd_valid_o = cmd_valid_r;
  assign i2c_txd_ready_o = pop_s;
  assign i2c_rxd_data_o  = rx_data_r;
  // The RX push coincides with acceptance of the master ACK/NACK bit
  assign i2c_rxd_valid_o = (state_r == ST_ACK) && (dir_r == DIR_RXD) && cmd_valid_r && phy_cmd_ready_i;
  assign tx_flush_o      = flush_r;
  assign st_busy_o       = busy_r;
  assign st_nack_o       = nack_r;

endmodule

// File: tb/tb_tqvp_dlmiles_i2c_seq.sv
// Directed bench: per-test tables of expected PHY commands (with the bit the PHY
// model returns) plus hand-written sequences for stall, restart and reset cases.
`timescale 1ns/1ps
module tb_tqvp_dlmiles_i2c_seq;
  import tqvp_dlmiles_i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ctl_enable_i = 1'b0;
  logic       stb_restart_i = 1'b0;
  logic       stb_stop_i = 1'b0;
  logic       stb_clear_i = 1'b0;
  logic [8:0] i2c_txd_data_i = 9'd0;
  logic       i2c_txd_valid_i = 1'b0;
  logic       i2c_txd_ready_o;
  logic [7:0] i2c_rxd_data_o;
  logic       i2c_rxd_valid_o;
  logic       st_rx_full_i = 1'b0;
  logic [1:0] phy_cmd_o;
  logic       phy_wbit_o;
  logic       phy_cmd_valid_o;
  logic       phy_cmd_ready_i = 1'b0;
  logic       phy_done_i = 1'b0;
  logic       phy_rbit_i = 1'b0;
  logic       tx_flush_o;
  logic       st_busy_o;
  logic       st_nack_o;

  tqvp_dlmiles_i2c_seq #(.NACK_FLUSH(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ctl_enable_i(ctl_enable_i),
    .stb_restart_i(stb_restart_i), .stb_stop_i(stb_stop_i), .stb_clear_i(stb_clear_i),
    .i2c_txd_data_i(i2c_txd_data_i), .i2c_txd_valid_i(i2c_txd_valid_i),
    .i2c_txd_ready_o(i2c_txd_ready_o), .i2c_rxd_data_o(i2c_rxd_data_o),
    .i2c_rxd_valid_o(i2c_rxd_valid_o), .st_rx_full_i(st_rx_full_i),
    .phy_cmd_o(phy_cmd_o), .phy_wbit_o(phy_wbit_o), .phy_cmd_valid_o(phy_cmd_valid_o),
    .phy_cmd_ready_i(phy_cmd_ready_i), .phy_done_i(phy_done_i), .phy_rbit_i(phy_rbit_i),
    .tx_flush_o(tx_flush_o), .st_busy_o(st_busy_o), .st_nack_o(st_nack_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] cmd;
    logic       wbit;
    logic       rbit;
    logic       clr;
  } step_t;

  step_t      steps[$];
  logic [8:0] txq[$];
  int         checks = 0;
  int         errors = 0;
  int         pop_cnt = 0;
  int         rx_cnt = 0;
  int         flush_cnt = 0;
  logic [7:0] rx_last = 8'h00;
  logic       pop_pend = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // TX FIFO / RX FIFO model: updates FIFO head after each edge, samples strobes mid-low-phase
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (pop_pend && txq.size() != 0) void'(txq.pop_front());
      pop_pend = 1'b0;
      i2c_txd_valid_i = (txq.size() != 0);
      i2c_txd_data_i  = (txq.size() != 0) ? txq[0] : 9'd0;
      #2;
      if (i2c_txd_ready_o && i2c_txd_valid_i) begin
        pop_cnt++;
        pop_pend = 1'b1;
      end
      if (i2c_rxd_valid_o) begin
        rx_cnt++;
        rx_last = i2c_rxd_data_o;
      end
      if (tx_flush_o) begin
        flush_cnt++;
        txq.delete();
      end
    end
  end

  task automatic add(input logic [1:0] c, input logic w, input logic r);
    step_t s;
    s.cmd = c; s.wbit = w; s.rbit = r; s.clr = 1'b0;
    steps.push_back(s);
  endtask

  task automatic add_write(input logic [7:0] b, input logic ack_rbit);
    for (int i = 7; i >= 0; i--) add(CMD_WBIT, b[i], 1'b0);
    add(CMD_RBIT, 1'b0, ack_rbit);
  endtask

  task automatic add_read(input logic [7:0] b, input logic nack);
    for (int i = 7; i >= 0; i--) add(CMD_RBIT, 1'b0, b[i]);
    add(CMD_WBIT, nack, 1'b0);
  endtask

  task automatic phy_step(input step_t s, input string nm);
    int n = 0;
    while (phy_cmd_valid_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_valid"}, {31'd0, phy_cmd_valid_o}, 32'd1);
    if (phy_cmd_valid_o === 1'b1) begin
      check({nm, "_cmd"}, {30'd0, phy_cmd_o}, {30'd0, s.cmd});
      if (s.cmd == CMD_WBIT) check({nm, "_wbit"}, {31'd0, phy_wbit_o}, {31'd0, s.wbit});
      phy_cmd_ready_i = 1'b1;
      @(negedge clk);
      phy_cmd_ready_i = 1'b0;
      @(negedge clk);
      phy_done_i  = 1'b1;
      phy_rbit_i  = s.rbit;
      stb_clear_i = s.clr;
      @(negedge clk);
      phy_done_i  = 1'b0;
      phy_rbit_i  = 1'b0;
      stb_clear_i = 1'b0;
    end
  endtask

  task automatic run_steps(input string tn, input int lo, input int hi);
    for (int i = lo; i < hi && i < steps.size(); i++) phy_step(steps[i], $sformatf("%s_s%0d", tn, i));
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    if (which == 0) stb_stop_i = 1'b1;
    else if (which == 1) stb_restart_i = 1'b1;
    else stb_clear_i = 1'b1;
    @(negedge clk);
    stb_stop_i = 1'b0; stb_restart_i = 1'b0; stb_clear_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int p0, r0, f0, bad;
    logic [1:0] hold_cmd;
    logic       hold_wbit;

    // Reset state
    @(negedge clk);
    check("rst_valid", {31'd0, phy_cmd_valid_o}, 32'd0);
    check("rst_cmd", {30'd0, phy_cmd_o}, 32'd0);
    check("rst_busy", {31'd0, st_busy_o}, 32'd0);
    check("rst_nack", {31'd0, st_nack_o}, 32'd0);
    check("rst_pop", {31'd0, i2c_txd_ready_o}, 32'd0);
    rst_n = 1'b1;
    ctl_enable_i = 1'b1;

    // Test 1: restart in IDLE ignored; write 0xA5 with ACK, then STOP
    pulse(1);
    p0 = pop_cnt;
    txq.push_back({DIR_TXD, 8'hA5});
    pulse(0);
    steps.delete();
    add(CMD_START, 1'b0, 1'b0);
    add_write(8'hA5, 1'b0);
    add(CMD_STOP, 1'b0, 1'b0);
    run_steps("t1", 0, 1);
    check("t1_busy_set", {31'd0, st_busy_o}, 32'd1);
    run_steps("t1", 1, steps.size());
    check("t1_busy_clr", {31'd0, st_busy_o}, 32'd0);
    check("t1_pops", pop_cnt - p0, 32'd1);
    repeat (5) @(negedge clk);
    check("t1_idle", {31'd0, phy_cmd_valid_o}, 32'd0);

    // Test 2: write 0x51, read 0xC3 with master NACK, then STOP
    p0 = pop_cnt; r0 = rx_cnt;
    txq.push_back({DIR_TXD, 8'h51});
    txq.push_back({DIR_RXD, 8'h01});
    pulse(0);
    steps.delete();
    add(CMD_START, 1'b0, 1'b0);
    add_write(8'h51, 1'b0);
    add_read(8'hC3, 1'b1);
    add(CMD_STOP, 1'b0, 1'b0);
    run_steps("t2", 0, steps.size());
    check("t2_pops", pop_cnt - p0, 32'd2);
    check("t2_rxcnt", rx_cnt - r0, 32'd1);
    check("t2_rxdata", {24'd0, rx_last}, 32'hC3);

    // Test 3: write NACKed with a simultaneous clear; queued entry flushed
    p0 = pop_cnt; f0 = flush_cnt;
    txq.push_back({DIR_TXD, 8'h3C});
    txq.push_back({DIR_TXD, 8'h11});
    steps.delete();
    add(CMD_START, 1'b0, 1'b0);
    add_write(8'h3C, 1'b1);
    steps[9].clr = 1'b1;
    add(CMD_STOP, 1'b0, 1'b0);
    run_steps("t3", 0, 10);
    check("t3_nack_wins", {31'd0, st_nack_o}, 32'd1);
    run_steps("t3", 10, steps.size());
    repeat (10) @(negedge clk);
    check("t3_flush", flush_cnt - f0, 32'd1);
    check("t3_pops", pop_cnt - p0, 32'd1);
    check("t3_idle", {31'd0, phy_cmd_valid_o}, 32'd0);
    check("t3_nack_sticky", {31'd0, st_nack_o}, 32'd1);
    pulse(2);
    check("t3_nack_clr", {31'd0, st_nack_o}, 32'd0);

    // Test 4: read stalls while RX FIFO full, then proceeds
    p0 = pop_cnt; r0 = rx_cnt;
    st_rx_full_i = 1'b1;
    txq.push_back({DIR_RXD, 8'h00});
    pulse(0);
    steps.delete();
    add(CMD_START, 1'b0, 1'b0);
    add_read(8'h5A, 1'b0);
    add(CMD_STOP, 1'b0, 1'b0);
    run_steps("t4", 0, 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (phy_cmd_valid_o !== 1'b0 || pop_cnt != p0) bad = 1;
    end
    check("t4_stall", bad, 32'd0);
    st_rx_full_i = 1'b0;
    run_steps("t4", 1, steps.size());
    check("t4_pops", pop_cnt - p0, 32'd1);
    check("t4_rxcnt", rx_cnt - r0, 32'd1);
    check("t4_rxdata", {24'd0, rx_last}, 32'h5A);

    // Test 5: write 0xA0, repeated START, read 0x96
    p0 = pop_cnt; r0 = rx_cnt;
    txq.push_back({DIR_TXD, 8'hA0});
    txq.push_back({DIR_RXD, 8'h01});
    steps.delete();
    add(CMD_START, 1'b0, 1'b0);
    add_write(8'hA0, 1'b0);
    add(CMD_START, 1'b0, 1'b0);
    add_read(8'h96, 1'b1);
    add(CMD_STOP, 1'b0, 1'b0);
    run_steps("t5", 0, 2);
    pulse(1);
    pulse(0);
    run_steps("t5", 2, steps.size());
    check("t5_pops", pop_cnt - p0, 32'd2);
    check("t5_rxdata", {24'd0, rx_last}, 32'h96);
    check("t5_busy_clr", {31'd0, st_busy_o}, 32'd0);

    // Test 7: enable dropped mid-byte: byte and ACK finish, STOP, second entry kept
    p0 = pop_cnt;
    txq.push_back({DIR_TXD, 8'hC3});
    txq.push_back({DIR_TXD, 8'h0F});
    steps.delete();
    add(CMD_START, 1'b0, 1'b0);
    add_write(8'hC3, 1'b0);
    add(CMD_STOP, 1'b0, 1'b0);
    run_steps("t7", 0, 2);
    ctl_enable_i = 1'b0;
    run_steps("t7", 2, steps.size());
    repeat (8) @(negedge clk);
    check("t7_pops", pop_cnt - p0, 32'd1);
    check("t7_idle", {31'd0, phy_cmd_valid_o}, 32'd0);
    check("t7_busy", {31'd0, st_busy_o}, 32'd0);
    txq.delete();
    ctl_enable_i = 1'b1;
    repeat (2) @(negedge clk);

    // Test 6: PHY stalls ready during BITS, then async reset
    txq.push_back({DIR_TXD, 8'hFF});
    steps.delete();
    add(CMD_START, 1'b0, 1'b0);
    add(CMD_WBIT, 1'b1, 1'b0);
    add(CMD_WBIT, 1'b1, 1'b0);
    run_steps("t6", 0, steps.size());
    bad = 0;
    for (int i = 0; i < 100 && phy_cmd_valid_o !== 1'b1; i++) @(negedge clk);
    hold_cmd = phy_cmd_o;
    hold_wbit = phy_wbit_o;
    check("t6_hold_cmd", {30'd0, hold_cmd}, {30'd0, CMD_WBIT});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (phy_cmd_valid_o !== 1'b1 || phy_cmd_o !== hold_cmd || phy_wbit_o !== hold_wbit) bad = 1;
    end
    check("t6_hold_stable", bad, 32'd0);
    check("t6_busy", {31'd0, st_busy_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_outs", {21'd0, phy_cmd_valid_o, phy_cmd_o, phy_wbit_o, st_busy_o, st_nack_o,
                          i2c_txd_ready_o, i2c_rxd_valid_o, tx_flush_o, (i2c_rxd_data_o != 8'h00)}, 32'd0);
    txq.delete();
    @(negedge clk);
    pop_pend = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_post_idle", {31'd0, phy_cmd_valid_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
